umi_tx_burst_sim: RTL

- Parametrised, burst-capable successor to the single-flit UMI TX simulation shim.
- Accepts UMI flits with an upstream `in_last` marker and buffers them in a DEPTH-entry FIFO.
- Drives a switchboard-style TX interface (data/dest/last/valid/ready) that feeds sb_tx_sim in the sim top.
- Holds dest constant across a burst, bounds burst length, and optionally holds each burst until it is fully buffered (store-and-forward).

---
 rtl/umi_tx_burst_sim.sv | 102 ++++++++++
 1 files changed

// File: rtl/umi_tx_burst_sim.sv
// Burst-capable UMI TX shim: buffers flits in a FIFO and drives a switchboard TX port
// with dest held per burst, bounded burst length and optional store-and-forward.
module umi_tx_burst_sim #(
  parameter int DW        = 256,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int STORE_FWD = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] packet,
  input  logic          valid,
  input  logic          in_last,
  output logic          ready,
  output logic [DW-1:0] sb_data,
  output logic [31:0]   sb_dest,
  output logic          sb_last,
  output logic          sb_valid,
  input  logic          sb_ready,
  output logic          burst_err,
  output logic [31:0]   bursts_sent
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int BW = $clog2(DEPTH + 1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_lmem;
  logic [AW:0]      r_wptr, r_rptr;
  logic [CW-1:0]    r_in_cnt;
  logic [BW-1:0]    r_cb;
  logic             r_out_first;
  logic [31:0]      r_dest_q, r_sent;
  logic             r_err;

  logic          w_empty, w_full, w_push, w_pop, w_last_eff;
  logic [31:0]   w_head_dest;
  logic [AW-1:0] w_ra, w_wa;

  assign w_ra    = r_rptr[AW-1:0];
  assign w_wa    = r_wptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_wa == w_ra);

  // No bypass: a full FIFO refuses input even when the head pops this cycle.
  assign ready      = !rst && !w_full;
  assign w_push     = valid && ready;
  assign w_last_eff = in_last || (r_in_cnt == CW'(MAX_BURST - 1));

  assign sb_valid = !rst && !w_empty && ((STORE_FWD == 0) || (r_cb != '0));
  assign w_pop    = sb_valid && sb_ready;

  assign sb_data     = r_mem[w_ra];
  assign sb_last     = r_lmem[w_ra];
  assign w_head_dest = {16'h0000, sb_data[DW-1 -: 16]};
  assign sb_dest     = r_out_first ? w_head_dest : r_dest_q;

  assign burst_err   = r_err;
  assign bursts_sent = r_sent;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wa]  <= packet;
      r_lmem[w_wa] <= w_last_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_in_cnt    <= '0;
      r_cb        <= '0;
      r_out_first <= 1'b1;
      r_dest_q    <= '0;
      r_sent      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr   <= r_wptr + (AW+1)'(1);
        r_in_cnt <= w_last_eff ? '0 : r_in_cnt + CW'(1);
        if (w_last_eff && !in_last) r_err <= 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
        if (r_out_first) r_dest_q <= w_head_dest;
        if (sb_last) begin
          r_out_first <= 1'b1;
          r_sent      <= r_sent + 32'd1;
        end else begin
          r_out_first <= 1'b0;
        end
      end
      // Complete-burst count gates store-and-forward release.
      case ({w_push && w_last_eff, w_pop && sb_last})
        2'b10:   r_cb <= r_cb + BW'(1);
        2'b01:   r_cb <= r_cb - BW'(1);
        default: r_cb <= r_cb;
      endcase
    end
  end
endmodule
